// File: rtl/nn_pkg.sv
// Shared definitions for the sonar sample path: feature geometry, collector
// state encoding and the slice-position helper.
package nn_pkg;

    localparam int BROJ_ZNACAJKI = 60;
    localparam int SIRINA        = 16;
    localparam int UZORAK_W      = BROJ_ZNACAJKI * SIRINA;
    localparam int IDX_W         = $clog2(BROJ_ZNACAJKI);
    localparam int POS_W         = $clog2(UZORAK_W);
    localparam int CNT_W         = 8;

    typedef enum logic [1:0] {
        PRIMANJE   = 2'd0,
        DISCARD    = 2'd1,
        SMIRIVANJE = 2'd2,
        GOTOVO     = 2'd3
    } stanje_e;

    // LSB position of feature k; feature 0 occupies the top slice.
    function automatic logic [POS_W-1:0] pozicija(input logic [IDX_W-1:0] k);
        int p;
        p = (BROJ_ZNACAJKI - 1 - int'(k)) * SIRINA;
        return POS_W'(p);
    endfunction

endpackage

// File: rtl/settle_brojac.sv
// Loadable down-counter that stops at zero and reports a zero flag.
module settle_brojac
    import nn_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ucitaj,
    input  logic [W-1:0] pocetna,
    input  logic         broji,
    output logic         nula
);

    logic [W-1:0] brojac_q;
    logic [W-1:0] brojac_d;

    // Next count: load wins over decrement, saturating at zero.
    always_comb begin
        brojac_d = brojac_q;
        if (ucitaj) begin
            brojac_d = pocetna;
        end else if (broji && (brojac_q != {W{1'b0}})) begin
            brojac_d = brojac_q - W'(1);
        end else begin
            brojac_d = brojac_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brojac_q <= {W{1'b0}};
        end else begin
            brojac_q <= brojac_d;
        end
    end

    assign nula = (brojac_q == {W{1'b0}});

endmodule

// File: rtl/uzorak_sakupljac.sv
// Collects a serial frame of sonar features into the packed uzorak bus,
// holds it for a settle window and hands it to the network with valid/ack.
module uzorak_sakupljac
    import nn_pkg::*;
#(
    parameter int SETTLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIRINA-1:0]   znacajka_in,
    input  logic                znacajka_valid,
    input  logic                znacajka_zadnji,
    output logic                znacajka_ready,
    output logic [UZORAK_W-1:0] uzorak,
    output logic                uzorak_valid,
    input  logic                uzorak_ack,
    output logic                greska
);

    localparam logic [IDX_W-1:0] ZADNJI_IDX = IDX_W'(BROJ_ZNACAJKI - 1);
    localparam logic [CNT_W-1:0] SETTLE_POC = CNT_W'(SETTLE_CYC - 1);

    stanje_e             stanje_q, stanje_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [UZORAK_W-1:0] uzorak_q, uzorak_d;
    logic                valid_q, valid_d;
    logic                greska_q, greska_d;
    logic                ready_q, ready_d;
    logic                prijenos_s;
    logic                ucitaj_s;
    logic                broji_s;
    logic                nula_s;
    logic [POS_W-1:0]    pos_s;

    settle_brojac #(.W(CNT_W)) u_settle (
        .clk     (clk),
        .rst     (rst),
        .ucitaj  (ucitaj_s),
        .pocetna (SETTLE_POC),
        .broji   (broji_s),
        .nula    (nula_s)
    );

    // Next-state, packing and output decode for the collector.
    always_comb begin
        prijenos_s = znacajka_valid && ready_q;
        pos_s      = pozicija(index_q);
        stanje_d   = stanje_q;
        index_d    = index_q;
        uzorak_d   = uzorak_q;
        greska_d   = 1'b0;
        valid_d    = 1'b0;
        ucitaj_s   = 1'b0;
        broji_s    = 1'b0;
        case (stanje_q)
            PRIMANJE: begin
                if (prijenos_s) begin
                    uzorak_d[pos_s +: SIRINA] = znacajka_in;
                    if (index_q == ZADNJI_IDX) begin
                        index_d = {IDX_W{1'b0}};
                        if (znacajka_zadnji) begin
                            stanje_d = SMIRIVANJE;
                            ucitaj_s = 1'b1;
                        end else begin
                            stanje_d = DISCARD;
                            greska_d = 1'b1;
                        end
                    end else if (znacajka_zadnji) begin
                        index_d  = {IDX_W{1'b0}};
                        greska_d = 1'b1;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end else begin
                    index_d = index_q;
                end
            end
            DISCARD: begin
                if (prijenos_s && znacajka_zadnji) begin
                    stanje_d = PRIMANJE;
                end else begin
                    stanje_d = DISCARD;
                end
            end
            SMIRIVANJE: begin
                broji_s = 1'b1;
                if (nula_s) begin
                    stanje_d = GOTOVO;
                end else begin
                    stanje_d = SMIRIVANJE;
                end
            end
            GOTOVO: begin
                // Ack only counts once valid is visible to the consumer.
                if (valid_q && uzorak_ack) begin
                    stanje_d = PRIMANJE;
                end else begin
                    stanje_d = GOTOVO;
                    valid_d  = 1'b1;
                end
            end
            default: begin
                stanje_d = PRIMANJE;
                index_d  = {IDX_W{1'b0}};
            end
        endcase
        ready_d = (stanje_d == PRIMANJE) || (stanje_d == DISCARD);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stanje_q <= PRIMANJE;
            index_q  <= {IDX_W{1'b0}};
            uzorak_q <= {UZORAK_W{1'b0}};
            valid_q  <= 1'b0;
            greska_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            stanje_q <= stanje_d;
            index_q  <= index_d;
            uzorak_q <= uzorak_d;
            valid_q  <= valid_d;
            greska_q <= greska_d;
            ready_q  <= ready_d;
        end
    end

    assign znacajka_ready = ready_q;
    assign uzorak         = uzorak_q;
    assign uzorak_valid   = valid_q;
    assign greska         = greska_q;

endmodule

// File: tb/tb_uzorak_sakupljac.sv
// Randomized self-checking bench for uzorak_sakupljac against a frame-level model.
module tb_uzorak_sakupljac;
    import nn_pkg::*;

    localparam int SETTLE = 4;
    localparam int LAT    = SETTLE + 1;
    localparam int PERIOD_B2B = 2 * (BROJ_ZNACAJKI + SETTLE + 2);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [SIRINA-1:0]   znacajka_in = '0;
    logic                znacajka_valid = 1'b0;
    logic                znacajka_zadnji = 1'b0;
    logic                znacajka_ready;
    logic [UZORAK_W-1:0] uzorak;
    logic                uzorak_valid;
    logic                uzorak_ack = 1'b0;
    logic                greska;

    uzorak_sakupljac #(.SETTLE_CYC(SETTLE)) dut (
        .clk             (clk),
        .rst             (rst),
        .znacajka_in     (znacajka_in),
        .znacajka_valid  (znacajka_valid),
        .znacajka_zadnji (znacajka_zadnji),
        .znacajka_ready  (znacajka_ready),
        .uzorak          (uzorak),
        .uzorak_valid    (uzorak_valid),
        .uzorak_ack      (uzorak_ack),
        .greska          (greska)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_total = 0;
    int n_pass  = 0;

    logic [SIRINA-1:0]   rijeci [0:69];
    int                  sent, g_cnt, g_at, first_cyc, v_seen, lat, ack_cyc;
    logic                rdy_bad;
    logic [UZORAK_W-1:0] ocekivani;

    // Expected bus: features shifted in one after another, first ends up on top.
    function automatic logic [UZORAK_W-1:0] model_uzorka();
        logic [UZORAK_W-1:0] r;
        r = '0;
        for (int k = 0; k < BROJ_ZNACAJKI; k++)
            r = {r[UZORAK_W-SIRINA-1:0], rijeci[k]};
        return r;
    endfunction

    task automatic korak();
        @(posedge clk);
        #1;
    endtask

    task automatic napuni(input bit brojevi);
        for (int k = 0; k < 70; k++)
            rijeci[k] = brojevi ? SIRINA'(k + 1) : SIRINA'($urandom);
    endtask

    // Drive n words; record transfers, greska pulses and first-transfer cycle.
    task automatic posalji(input int n, input bit zadnji_na_kraju, input bit praznine);
        int  timeout;
        bit  v;
        bit  r;
        timeout = 0; sent = 0; g_cnt = 0; g_at = -1; first_cyc = -1;
        while (sent < n && timeout < 1000) begin
            v = praznine ? ($urandom_range(0, 2) != 0) : 1'b1;
            znacajka_valid  = v;
            znacajka_in     = rijeci[sent];
            znacajka_zadnji = zadnji_na_kraju && (sent == n - 1);
            r = znacajka_ready;
            korak();
            timeout++;
            if (v && r) begin
                sent++;
                if (sent == 1) first_cyc = cyc_cnt;
            end
            if (greska) begin
                g_cnt++;
                g_at = sent;
            end
        end
        znacajka_valid  = 1'b0;
        znacajka_zadnji = 1'b0;
        n_total++;
        if (sent != n) $display("FAIL send_words: transferred %0d required %0d", sent, n);
        else n_pass++;
    endtask

    // Count cycles from the last-transfer edge until uzorak_valid; ready must stay low.
    task automatic cekaj_valid(output int c);
        c = 0;
        rdy_bad = 1'b0;
        while (uzorak_valid !== 1'b1 && c < 50) begin
            if (znacajka_ready !== 1'b0) rdy_bad = 1'b1;
            korak();
            c++;
        end
        if (znacajka_ready !== 1'b0) rdy_bad = 1'b1;
        n_total++;
        if (rdy_bad) $display("FAIL ready_in_settle: ready seen high, required low");
        else n_pass++;
    endtask

    task automatic pazi(input int n);
        v_seen = 0;
        for (int i = 0; i < n; i++) begin
            korak();
            if (greska) g_cnt++;
            if (uzorak_valid) v_seen++;
        end
    endtask

    task automatic potvrdi(output int c);
        uzorak_ack = 1'b1;
        korak();
        uzorak_ack = 1'b0;
        c = cyc_cnt;
        n_total++;
        if (uzorak_valid !== 1'b0 || znacajka_ready !== 1'b1)
            $display("FAIL ack_release: valid=%b ready=%b required valid=0 ready=1", uzorak_valid, znacajka_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        korak(); korak(); korak();
        n_total++;
        if (znacajka_ready !== 1'b0 || uzorak_valid !== 1'b0 || greska !== 1'b0)
            $display("FAIL reset_ctrl: ready=%b valid=%b greska=%b required 0 0 0", znacajka_ready, uzorak_valid, greska);
        else n_pass++;
        n_total++;
        if (uzorak !== {UZORAK_W{1'b0}}) $display("FAIL reset_uzorak: got %h required 0", uzorak);
        else n_pass++;
        rst = 1'b0;
        korak();
        n_total++;
        if (znacajka_ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", znacajka_ready);
        else n_pass++;
    endtask

    task automatic test_osnovni();
        napuni(1'b1);
        posalji(BROJ_ZNACAJKI, 1'b1, 1'b0);
        cekaj_valid(lat);
        n_total++;
        if (lat != LAT) $display("FAIL basic_latency: got %0d required %0d", lat, LAT);
        else n_pass++;
        n_total++;
        if (uzorak[959:944] !== 16'h0001) $display("FAIL basic_first_word: got %h required 0001", uzorak[959:944]);
        else n_pass++;
        n_total++;
        if (uzorak[15:0] !== 16'h003C) $display("FAIL basic_last_word: got %h required 003c", uzorak[15:0]);
        else n_pass++;
        n_total++;
        if (uzorak !== model_uzorka()) $display("FAIL basic_uzorak: got %h required %h", uzorak, model_uzorka());
        else n_pass++;
        n_total++;
        if (g_cnt != 0) $display("FAIL basic_no_greska: got %0d pulses required 0", g_cnt);
        else n_pass++;
        potvrdi(ack_cyc);
    endtask

    task automatic test_praznine_drzanje();
        napuni(1'b0);
        posalji(BROJ_ZNACAJKI, 1'b1, 1'b1);
        cekaj_valid(lat);
        n_total++;
        if (lat != LAT) $display("FAIL gaps_latency: got %0d required %0d", lat, LAT);
        else n_pass++;
        ocekivani = model_uzorka();
        v_seen = 0;
        rdy_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            korak();
            if (uzorak_valid === 1'b1 && uzorak === ocekivani) v_seen++;
            if (znacajka_ready !== 1'b0) rdy_bad = 1'b1;
        end
        n_total++;
        if (v_seen != 10) $display("FAIL hold_stable: got %0d good cycles required 10", v_seen);
        else n_pass++;
        n_total++;
        if (rdy_bad) $display("FAIL hold_ready: ready seen high, required low");
        else n_pass++;
        potvrdi(ack_cyc);
    endtask

    task automatic test_dobar_okvir();
        napuni(1'b0);
        posalji(BROJ_ZNACAJKI, 1'b1, 1'b0);
        cekaj_valid(lat);
        n_total++;
        if (lat != LAT) $display("FAIL frame_latency: got %0d required %0d", lat, LAT);
        else n_pass++;
        n_total++;
        if (uzorak !== model_uzorka()) $display("FAIL frame_uzorak: got %h required %h", uzorak, model_uzorka());
        else n_pass++;
        potvrdi(ack_cyc);
    endtask

    task automatic test_kratki();
        napuni(1'b0);
        posalji(30, 1'b1, 1'b0);
        pazi(12);
        n_total++;
        if (g_cnt != 1 || g_at != 30)
            $display("FAIL short_greska: pulses=%0d at=%0d required 1 at 30", g_cnt, g_at);
        else n_pass++;
        n_total++;
        if (v_seen != 0) $display("FAIL short_no_valid: got %0d valid cycles required 0", v_seen);
        else n_pass++;
        test_dobar_okvir();
    endtask

    task automatic test_dugi();
        napuni(1'b0);
        posalji(70, 1'b1, 1'b0);
        pazi(12);
        n_total++;
        if (g_cnt != 1 || g_at != BROJ_ZNACAJKI)
            $display("FAIL long_greska: pulses=%0d at=%0d required 1 at 60", g_cnt, g_at);
        else n_pass++;
        n_total++;
        if (v_seen != 0) $display("FAIL long_no_valid: got %0d valid cycles required 0", v_seen);
        else n_pass++;
        test_dobar_okvir();
    endtask

    task automatic test_async_reset();
        napuni(1'b0);
        posalji(45, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        n_total++;
        if (znacajka_ready !== 1'b0 || uzorak_valid !== 1'b0 || uzorak !== {UZORAK_W{1'b0}})
            $display("FAIL rst_mid_frame: ready=%b valid=%b uzorak_zero=%b required 0 0 1",
                     znacajka_ready, uzorak_valid, uzorak === {UZORAK_W{1'b0}});
        else n_pass++;
        #2 rst = 1'b0;
        korak();
        test_dobar_okvir();
        napuni(1'b0);
        posalji(BROJ_ZNACAJKI, 1'b1, 1'b0);
        korak();
        korak();
        #3 rst = 1'b1;
        #1;
        n_total++;
        if (znacajka_ready !== 1'b0 || uzorak_valid !== 1'b0 || uzorak !== {UZORAK_W{1'b0}})
            $display("FAIL rst_mid_settle: ready=%b valid=%b uzorak_zero=%b required 0 0 1",
                     znacajka_ready, uzorak_valid, uzorak === {UZORAK_W{1'b0}});
        else n_pass++;
        #2 rst = 1'b0;
        korak();
        test_dobar_okvir();
    endtask

    task automatic test_back_to_back();
        int a;
        napuni(1'b0);
        posalji(BROJ_ZNACAJKI, 1'b1, 1'b0);
        a = first_cyc;
        cekaj_valid(lat);
        n_total++;
        if (uzorak !== model_uzorka()) $display("FAIL b2b_first: got %h required %h", uzorak, model_uzorka());
        else n_pass++;
        potvrdi(ack_cyc);
        for (int k = 0; k < BROJ_ZNACAJKI; k++) rijeci[k] = ~rijeci[k];
        posalji(BROJ_ZNACAJKI, 1'b1, 1'b0);
        cekaj_valid(lat);
        n_total++;
        if (uzorak !== model_uzorka()) $display("FAIL b2b_second: got %h required %h", uzorak, model_uzorka());
        else n_pass++;
        potvrdi(ack_cyc);
        n_total++;
        if (ack_cyc - a + 1 != PERIOD_B2B)
            $display("FAIL b2b_cycles: got %0d required %0d", ack_cyc - a + 1, PERIOD_B2B);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_osnovni();
        test_praznine_drzanje();
        test_kratki();
        test_dugi();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
